// File: rtl/csr_access_ctrl.sv
`default_nettype none
// ============================================================================
// Module     : csr_access_ctrl
// Description: Initiator for the core CSR port. It issues a CSRRW/RS/RC access
//              for one cycle and returns the old CSR value with an error flag.
//              CSR_RO_CHECK_EN rejects writes to the read-only space addr[11:10]==2'b11.
// Revision   : 1.0  initial release
// ============================================================================
module csr_access_ctrl #(
    parameter logic [31:0] ERR_RDATA = 32'h0000_0000,
    parameter int          CNT_W     = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             req_valid_i,
    output logic             req_ready_o,
    input  logic [11:0]      req_addr_i,
    input  logic [31:0]      req_data_i,
    input  logic [1:0]       req_op_i,
    input  logic             req_nowr_i,
    output logic             rsp_valid_o,
    input  logic             rsp_ready_i,
    output logic [31:0]      rsp_data_o,
    output logic             rsp_err_o,
    output logic [11:0]      csr_addr_o,
    output logic [31:0]      csr_data_o,
    output logic [1:0]       csr_op_o,
    output logic             csr_we_o,
    input  logic [31:0]      csr_data_i,
    output logic [CNT_W-1:0] err_cnt_o
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_RESP  = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] c_cnt_max = '1;

    state_t r_state;
    state_t w_state_nxt;
    logic   r_err;
    logic   w_req_hs;
    logic   w_rsp_hs;
    logic   w_wr;
    logic   w_err;

    assign req_ready_o = (r_state == ST_IDLE);
    assign w_req_hs    = req_valid_i & req_ready_o;
    assign w_rsp_hs    = rsp_valid_o & rsp_ready_i;

    // RS/RC with a zero operand read without writing; RW always writes.
    assign w_wr = (req_op_i == 2'b01) | ((req_op_i != 2'b00) & ~req_nowr_i);

`ifdef CSR_RO_CHECK_EN
    assign w_err = (req_op_i == 2'b00) | (w_wr & (req_addr_i[11:10] == 2'b11));
`else
    assign w_err = (req_op_i == 2'b00);
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:  if (w_req_hs) w_state_nxt = ST_ISSUE;
            ST_ISSUE: w_state_nxt = ST_RESP;
            ST_RESP:  if (w_rsp_hs) w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_err       <= 1'b0;
            rsp_valid_o <= 1'b0;
            rsp_err_o   <= 1'b0;
            rsp_data_o  <= 32'h0;
            csr_addr_o  <= 12'h0;
            csr_data_o  <= 32'h0;
            csr_op_o    <= 2'b00;
            csr_we_o    <= 1'b0;
            err_cnt_o   <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_req_hs) begin
                        csr_addr_o <= req_addr_i;
                        csr_data_o <= req_data_i;
                        csr_op_o   <= req_op_i;
                        csr_we_o   <= w_wr & ~w_err;
                        r_err      <= w_err;
                    end
                end
                ST_ISSUE: begin
                    rsp_data_o  <= r_err ? ERR_RDATA : csr_data_i;
                    rsp_err_o   <= r_err;
                    rsp_valid_o <= 1'b1;
                    csr_we_o    <= 1'b0;
                    csr_op_o    <= 2'b00;
                end
                ST_RESP: begin
                    if (w_rsp_hs) begin
                        rsp_valid_o <= 1'b0;
                        if (rsp_err_o && (err_cnt_o != c_cnt_max)) begin
                            err_cnt_o <= err_cnt_o + 1'b1;
                        end
                    end
                end
                default: begin
                    csr_we_o <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_csr_access_ctrl.sv
`default_nettype none
// ============================================================================
// Module     : tb_csr_access_ctrl
// Description: Self-checking bench for csr_access_ctrl with directed and random
//              accesses against a rule-level reference model.
// Revision   : 1.0  initial release
// ============================================================================
module tb_csr_access_ctrl;

    localparam logic [31:0] ERR_RDATA = 32'hBAD0_C5A5;
    localparam int          CNT_W     = 2;
`ifdef CSR_RO_CHECK_EN
    localparam bit RO_EN = 1'b1;
`else
    localparam bit RO_EN = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             req_valid = 1'b0;
    logic             req_ready;
    logic [11:0]      req_addr = '0;
    logic [31:0]      req_data = '0;
    logic [1:0]       req_op = '0;
    logic             req_nowr = 1'b0;
    logic             rsp_valid;
    logic             rsp_ready = 1'b0;
    logic [31:0]      rsp_data;
    logic             rsp_err;
    logic [11:0]      csr_addr;
    logic [31:0]      csr_data;
    logic [1:0]       csr_op;
    logic             csr_we;
    logic [31:0]      csr_rdata = '0;
    logic [CNT_W-1:0] err_cnt;

    int n_chk  = 0;
    int n_pass = 0;
    int n_fail = 0;
    int model_cnt = 0;

    csr_access_ctrl #(.ERR_RDATA(ERR_RDATA), .CNT_W(CNT_W)) dut (
        .clk_i(clk), .rst_i(rst),
        .req_valid_i(req_valid), .req_ready_o(req_ready),
        .req_addr_i(req_addr), .req_data_i(req_data),
        .req_op_i(req_op), .req_nowr_i(req_nowr),
        .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready),
        .rsp_data_o(rsp_data), .rsp_err_o(rsp_err),
        .csr_addr_o(csr_addr), .csr_data_o(csr_data),
        .csr_op_o(csr_op), .csr_we_o(csr_we),
        .csr_data_i(csr_rdata), .err_cnt_o(err_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input bit ok);
        n_chk++;
        if (ok) begin
            n_pass++;
        end else begin
            n_fail++;
            $error("FAIL %s", tag);
        end
    endtask

    // Architectural view: which accesses write, and which are illegal.
    function automatic bit writes(input logic [1:0] op, input logic nowr);
        return (op == 2'd1) || ((op == 2'd2 || op == 2'd3) && !nowr);
    endfunction

    function automatic bit is_err(input logic [11:0] a, input logic [1:0] op, input logic nowr);
        return (op == 2'd0) || (RO_EN && writes(op, nowr) && (a >= 12'hC00));
    endfunction

    task automatic do_access(input logic [11:0] a, input logic [31:0] d, input logic [1:0] op,
                             input logic nowr, input logic [31:0] rdata, input int bp);
        bit          e;
        bit          wr;
        logic [31:0] exp_data;
        int          w;
        e        = is_err(a, op, nowr);
        wr       = writes(op, nowr) && !e;
        exp_data = e ? ERR_RDATA : rdata;
        req_valid = 1'b1; req_addr = a; req_data = d; req_op = op; req_nowr = nowr;
        w = 0;
        while (!req_ready && w < 10) begin
            tick();
            w++;
        end
        chk("req_ready_wait", req_ready === 1'b1);
        tick();
        req_valid = 1'b0;
        req_data  = $urandom;
        csr_rdata = rdata;
        rsp_ready = (bp == 0);
        chk("issue_we", csr_we === wr);
        chk("issue_op", csr_op === op);
        chk("issue_addr", csr_addr === a);
        chk("issue_data", csr_data === d);
        chk("issue_ready", req_ready === 1'b0);
        chk("issue_rsp_valid", rsp_valid === 1'b0);
        tick();
        csr_rdata = $urandom;
        chk("resp_valid", rsp_valid === 1'b1);
        chk("resp_data", rsp_data === exp_data);
        chk("resp_err", rsp_err === e);
        chk("resp_we_clr", csr_we === 1'b0);
        chk("resp_op_clr", csr_op === 2'd0);
        chk("resp_ready", req_ready === 1'b0);
        for (int i = 0; i < bp; i++) begin
            req_valid = 1'b1;
            tick();
            chk("bp_valid", rsp_valid === 1'b1);
            chk("bp_data", rsp_data === exp_data);
            chk("bp_err", rsp_err === e);
            chk("bp_req_ready", req_ready === 1'b0);
            chk("bp_we", csr_we === 1'b0);
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        if (e && model_cnt < (1 << CNT_W) - 1) model_cnt++;
        chk("done_valid", rsp_valid === 1'b0);
        chk("done_ready", req_ready === 1'b1);
        chk("done_cnt", err_cnt === model_cnt[CNT_W-1:0]);
    endtask

    initial begin
        logic [11:0] ra;
        logic [1:0]  rop;
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        chk("rst_ready", req_ready === 1'b1);
        chk("rst_rsp_valid", rsp_valid === 1'b0);
        chk("rst_rsp_err", rsp_err === 1'b0);
        chk("rst_rsp_data", rsp_data === 32'h0);
        chk("rst_csr_addr", csr_addr === 12'h0);
        chk("rst_csr_data", csr_data === 32'h0);
        chk("rst_csr_op", csr_op === 2'd0);
        chk("rst_csr_we", csr_we === 1'b0);
        chk("rst_err_cnt", err_cnt === '0);

        do_access(12'h305, 32'h8000_0100, 2'd1, 1'b0, 32'h0000_0000, 0);
        do_access(12'hC00, 32'h0000_0000, 2'd2, 1'b1, 32'h0000_002A, 0);
        do_access(12'h300, 32'h1234_5678, 2'd0, 1'b0, 32'h5555_AAAA, 0);
        do_access(12'hF11, 32'hFFFF_0000, 2'd1, 1'b0, 32'h0000_0042, 0);
        do_access(12'h341, 32'h0000_0004, 2'd3, 1'b0, 32'hCAFE_F00D, 5);

        // Reset while the access is in ISSUE: nothing may complete.
        req_valid = 1'b1; req_addr = 12'h340; req_data = 32'hA5A5_A5A5;
        req_op = 2'd1; req_nowr = 1'b0;
        tick();
        req_valid = 1'b0;
        chk("pre_rst_we", csr_we === 1'b1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        model_cnt = 0;
        chk("midrst_we", csr_we === 1'b0);
        chk("midrst_valid", rsp_valid === 1'b0);
        chk("midrst_ready", req_ready === 1'b1);
        chk("midrst_cnt", err_cnt === '0);
        tick();
        chk("midrst_no_rsp", rsp_valid === 1'b0);

        for (int i = 0; i < 5; i++) begin
            do_access(12'h300 + 12'(i), $urandom, 2'd0, 1'b0, $urandom, i % 2);
        end
        chk("sat_cnt", err_cnt === 2'd3);

        rst = 1'b1;
        tick();
        rst = 1'b0;
        model_cnt = 0;
        for (int i = 0; i < 30; i++) begin
            ra  = 12'($urandom);
            rop = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 2) == 0) ra[11:10] = 2'b11;
            do_access(ra, $urandom, rop, 1'($urandom_range(0, 1)), $urandom,
                      int'($urandom_range(0, 3)));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        if (n_fail == 0) $display("PASS");
        else $display("FAIL %0d checks failed", n_fail);
        $finish;
    end

endmodule
`default_nettype wire
